// File: rtl/switch_pkg.sv
// Shared types and helpers for the switch output-port logic (arbiter, fsm, fsm_top).
package switch_pkg;

  // Default data/address width, kept in step with the per-input fsm.
  localparam int W_WIDTH_DEF = 8;

  // Arbiter FSM: IDLE (no owner), OWN (packet in flight), GAP (one separation cycle).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  // Index width for a requester count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Scans req starting at rr_ptr and wrapping modulo N_REQ; the first set line wins.
// rr_ptr must be below N_REQ.
module rr_pick
  import switch_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    valid  = |req;
    winner = '0;
    idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IDX_W'((int'(rr_ptr) + i) % N_REQ);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/port_arbiter.sv
// port_arbiter: round-robin, whole-packet arbiter for one switch output port.
// The owner keeps the port from its grant until an eop beat or until it drops req;
// its wr_en/data are forwarded with one cycle of latency, other writers are ignored.
// Optional build macro ARB_TIMEOUT_EN: force release of an owner that stays silent
// for TIMEOUT_CYC cycles and pulse timeout_err. Without it timeout_err is tied 0.
module port_arbiter
  import switch_pkg::*;
#(
  parameter int W_WIDTH     = W_WIDTH_DEF,
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sw_en,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           wr_en_in,
  input  logic [N_REQ-1:0]           eop,
  input  logic [N_REQ*W_WIDTH-1:0]   data_in,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           port_busy,
  output logic                       wr_en,
  output logic [W_WIDTH-1:0]         data_out,
  output logic                       timeout_err
);

  localparam int IDX_W = idx_w(N_REQ);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_nxt;
  logic [IDX_W-1:0] own_idx, own_nxt;
  logic [IDX_W-1:0] next_ptr;
  logic [N_REQ-1:0] gnt_nxt, busy_nxt;
  logic             wr_en_nxt, tmo_err_nxt;
  logic [W_WIDTH-1:0] data_nxt;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  logic [W_WIDTH-1:0] data_arr [N_REQ];
  logic [W_WIDTH-1:0] own_data;
  logic own_wr, own_eop, own_req;
  logic rel_eop, rel_abort, rel_tmo, pkt_done;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Unpack the flat requester data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      data_arr[i] = data_in[i*W_WIDTH +: W_WIDTH];
    end
  end

  assign own_data = data_arr[own_idx];
  assign own_wr   = wr_en_in[own_idx];
  assign own_eop  = eop[own_idx];
  assign own_req  = req[own_idx];

  // A dropped req is an abort and wins over a coincident beat: nothing is forwarded.
  assign rel_abort = ~own_req;
  assign rel_eop   = own_wr & own_eop;
  assign pkt_done  = rel_abort | rel_eop | rel_tmo;

  // Pointer moves to the requester just after the releasing owner.
  assign next_ptr = (own_idx == IDX_W'(N_REQ - 1)) ? '0 : own_idx + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [TMO_W-1:0] tmo_cnt;

  // Count consecutive owner cycles without a write beat; zero outside OWN.
  always_ff @(posedge clk) begin
    if (!rst_n)              tmo_cnt <= '0;
    else if (state != OWN)   tmo_cnt <= '0;
    else if (own_wr)         tmo_cnt <= '0;
    else                     tmo_cnt <= tmo_cnt + 1'b1;
  end

  // The TIMEOUT_CYC-th silent owner cycle forces the release.
  assign rel_tmo = ~own_wr & (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign rel_tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: grant from IDLE, release from OWN, single GAP cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sw_en && pick_valid) state_nxt = OWN;
      OWN:     if (pkt_done)            state_nxt = GAP;
      GAP:                              state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered grant, busy, port and pointer signals.
  always_comb begin
    gnt_nxt     = gnt;
    busy_nxt    = port_busy;
    wr_en_nxt   = 1'b0;
    data_nxt    = data_out;
    tmo_err_nxt = 1'b0;
    own_nxt     = own_idx;
    rr_nxt      = rr_ptr;
    case (state)
      IDLE: begin
        if (sw_en && pick_valid) begin
          own_nxt           = pick_idx;
          gnt_nxt           = '0;
          gnt_nxt[pick_idx] = 1'b1;
          busy_nxt          = ~gnt_nxt;
        end
      end
      OWN: begin
        if (own_wr && !rel_abort) begin
          wr_en_nxt = 1'b1;
          data_nxt  = own_data;
        end
        if (pkt_done) begin
          gnt_nxt     = '0;
          busy_nxt    = '0;
          rr_nxt      = next_ptr;
          tmo_err_nxt = rel_tmo & ~rel_abort;
        end
      end
      default: ;
    endcase
  end

  // Output and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt         <= '0;
      port_busy   <= '0;
      wr_en       <= 1'b0;
      data_out    <= '0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      own_idx     <= '0;
    end else begin
      gnt         <= gnt_nxt;
      port_busy   <= busy_nxt;
      wr_en       <= wr_en_nxt;
      data_out    <= data_nxt;
      timeout_err <= tmo_err_nxt;
      rr_ptr      <= rr_nxt;
      own_idx     <= own_nxt;
    end
  end

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter (W_WIDTH=8, N_REQ=4, TIMEOUT_CYC=8).
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
module tb_port_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int TCYC = 8;

  logic           clk = 1'b0;
  logic           rst_n, sw_en;
  logic [N-1:0]   req, wr_en_in, eop;
  logic [W-1:0]   d [N];
  logic [N*W-1:0] data_in;
  logic [N-1:0]   gnt, port_busy;
  logic           wr_en;
  logic [W-1:0]   data_out;
  logic           timeout_err;

  int vectors     = 0;
  int miscompares = 0;

  assign data_in = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  port_arbiter #(
    .W_WIDTH     (W),
    .N_REQ       (N),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_en       (sw_en),
    .req         (req),
    .wr_en_in    (wr_en_in),
    .eop         (eop),
    .data_in     (data_in),
    .gnt         (gnt),
    .port_busy   (port_busy),
    .wr_en       (wr_en),
    .data_out    (data_out),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_port(input string tag, input logic [3:0] g, input logic [3:0] b,
                            input logic w, input logic [7:0] dd);
    check({tag, ".gnt"},       32'(gnt),       32'(g));
    check({tag, ".port_busy"}, 32'(port_busy), 32'(b));
    check({tag, ".wr_en"},     32'(wr_en),     32'(w));
    check({tag, ".data_out"},  32'(data_out),  32'(dd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] eg;
    logic [7:0] exp_data;

    // Reset values
    rst_n = 1'b0; sw_en = 1'b1; req = '0; wr_en_in = '0; eop = '0;
    for (int i = 0; i < N; i++) d[i] = '0;
    tick(); tick();
    check_port("reset", 4'b0000, 4'b0000, 1'b0, 8'h00);
    check("reset.timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    tick();
    check_port("idle", 4'b0000, 4'b0000, 1'b0, 8'h00);

    // T1: req0 sends a 3-beat packet
    req = 4'b0001;
    tick(); check_port("t1.grant", 4'b0001, 4'b1110, 1'b0, 8'h00);
    wr_en_in = 4'b0001; d[0] = 8'h11;
    tick(); check_port("t1.beat1", 4'b0001, 4'b1110, 1'b1, 8'h11);
    d[0] = 8'h22;
    tick(); check_port("t1.beat2", 4'b0001, 4'b1110, 1'b1, 8'h22);
    d[0] = 8'h33; eop = 4'b0001;
    tick(); check_port("t1.beat3", 4'b0000, 4'b0000, 1'b1, 8'h33);
    wr_en_in = '0; eop = '0; req = '0;
    tick(); check_port("t1.gap", 4'b0000, 4'b0000, 1'b0, 8'h33);

    // T3: req1 owns (pointer now 1), req3 writes 0xAA and must be dropped
    req = 4'b1010;
    tick(); check_port("t3.grant", 4'b0010, 4'b1101, 1'b0, 8'h33);
    wr_en_in = 4'b1000; d[3] = 8'hAA; d[1] = 8'h55;
    tick(); check_port("t3.intruder", 4'b0010, 4'b1101, 1'b0, 8'h33);
    wr_en_in = 4'b1010; eop = 4'b0010;
    tick(); check_port("t3.eop", 4'b0000, 4'b0000, 1'b1, 8'h55);
    req = '0; wr_en_in = '0; eop = '0;
    tick(); check_port("t3.gap", 4'b0000, 4'b0000, 1'b0, 8'h55);

    // T4: req2 owns then drops req mid-packet; pointer must move to 3
    req = 4'b0100;
    tick(); check_port("t4.grant", 4'b0100, 4'b1011, 1'b0, 8'h55);
    wr_en_in = 4'b0100; d[2] = 8'h77;
    tick(); check_port("t4.beat1", 4'b0100, 4'b1011, 1'b1, 8'h77);
    req = '0; wr_en_in = '0;
    tick(); check_port("t4.abort", 4'b0000, 4'b0000, 1'b0, 8'h77);
    tick(); check_port("t4.gap", 4'b0000, 4'b0000, 1'b0, 8'h77);
    req = 4'b0101;
    tick(); check_port("t4.rr_ptr", 4'b0001, 4'b1110, 1'b0, 8'h77);
    wr_en_in = 4'b0001; eop = 4'b0001; d[0] = 8'h99;
    tick(); check_port("t4.single", 4'b0000, 4'b0000, 1'b1, 8'h99);
    req = '0; wr_en_in = '0; eop = '0;
    tick(); check_port("t4.gap2", 4'b0000, 4'b0000, 1'b0, 8'h99);

    // Reset again so rotation restarts at requester 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_port("rst2", 4'b0000, 4'b0000, 1'b0, 8'h00);

    // T2: all requesting single-beat packets -> grants 0,1,2,3,0
    req = 4'b1111; wr_en_in = 4'b1111; eop = 4'b1111;
    for (int i = 0; i < N; i++) d[i] = 8'hA0 + 8'(i);
    exp_data = 8'h00;
    for (int k = 0; k < 5; k++) begin
      eg = 4'(1 << (k % 4));
      tick(); check_port("t2.grant", eg, ~eg, 1'b0, exp_data);
      exp_data = 8'hA0 + 8'(k % 4);
      tick(); check_port("t2.beat", 4'b0000, 4'b0000, 1'b1, exp_data);
      tick(); check_port("t2.gap", 4'b0000, 4'b0000, 1'b0, exp_data);
    end
    req = '0; wr_en_in = '0; eop = '0;

    // T5: sw_en drops during req1's packet; req3 waits for sw_en
    req = 4'b0010;
    tick(); check_port("t5.grant", 4'b0010, 4'b1101, 1'b0, 8'hA0);
    sw_en = 1'b0; req = 4'b1010; wr_en_in = 4'b0010; d[1] = 8'hC1;
    tick(); check_port("t5.beat1", 4'b0010, 4'b1101, 1'b1, 8'hC1);
    eop = 4'b0010; d[1] = 8'hC2;
    tick(); check_port("t5.eop", 4'b0000, 4'b0000, 1'b1, 8'hC2);
    req = 4'b1000; wr_en_in = '0; eop = '0;
    tick(); check_port("t5.gap", 4'b0000, 4'b0000, 1'b0, 8'hC2);
    tick(); check_port("t5.blocked1", 4'b0000, 4'b0000, 1'b0, 8'hC2);
    tick(); check_port("t5.blocked2", 4'b0000, 4'b0000, 1'b0, 8'hC2);
    sw_en = 1'b1;
    tick(); check_port("t5.resume", 4'b1000, 4'b0111, 1'b0, 8'hC2);

    // T6: owner 3 stays silent
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < TCYC; i++) begin
      tick();
      check_port("t6.hold", 4'b1000, 4'b0111, 1'b0, 8'hC2);
      check("t6.timeout_low", 32'(timeout_err), 32'd0);
    end
    tick();
    check_port("t6.release", 4'b0000, 4'b0000, 1'b0, 8'hC2);
    check("t6.timeout_pulse", 32'(timeout_err), 32'd1);
    req = '0;
    tick();
    check_port("t6.gap", 4'b0000, 4'b0000, 1'b0, 8'hC2);
    check("t6.timeout_end", 32'(timeout_err), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check_port("t6.hold", 4'b1000, 4'b0111, 1'b0, 8'hC2);
      check("t6.timeout_low", 32'(timeout_err), 32'd0);
    end
    req = '0;
    tick();
    check_port("t6.abort", 4'b0000, 4'b0000, 1'b0, 8'hC2);
    check("t6.timeout_low2", 32'(timeout_err), 32'd0);
    tick();
`endif

    // T7: reset in the middle of a packet from req2 (pointer is 0)
    req = 4'b0100;
    tick(); check_port("t7.grant", 4'b0100, 4'b1011, 1'b0, 8'hC2);
    wr_en_in = 4'b0100; d[2] = 8'hE5;
    tick(); check_port("t7.beat1", 4'b0100, 4'b1011, 1'b1, 8'hE5);
    rst_n = 1'b0;
    tick();
    check_port("t7.reset", 4'b0000, 4'b0000, 1'b0, 8'h00);
    check("t7.timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1; req = '0; wr_en_in = '0;
    tick(); check_port("t7.after", 4'b0000, 4'b0000, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
